lc3_regfile_cc: RTL and testbench
=================================

Name: lc3_regfile_cc

Overview:
- Register-file and condition-code stage directly upstream of the LC-3 ALU.
- Holds R0–R7 and supplies the ALU's Ra/Rb operands from SR1/SR2.
- Accepts the ALU result (or other writeback data) on a single write port.
- Maintains the LC-3 NZP condition-code register and evaluates BR conditions for the control FSM.

Parameters:
- DATA_W, 16, width of each register, write data and read data.
- CC_RESET, 3'b010, NZP value loaded on reset (Z set).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- sr1  input  3  read-port A register select (drives ra).
- sr2  input  3  read-port B register select (drives rb).
- dr  input  3  write destination register select.
- wdata  input  DATA_W  writeback data (ALU aluOut, memory data, PC etc.).
- reg_we  input  1  write enable for register dr.
- ld_cc  input  1  load NZP from wdata.
- br_nzp  input  3  BR instruction condition mask IR[11:9], bit order {n,z,p}.
- ra  output  DATA_W  operand A to ALU Ra.
- rb  output  DATA_W  operand B to ALU Rb.
- nzp  output  3  current condition codes {N,Z,P}.
- br_taken  output  1  branch condition satisfied.

Behaviour:
Reset:
- Asynchronous on reset high: R0–R7 <= 0, nzp <= CC_RESET.
- Holds while reset is high.
- ra and rb read 0 during reset; br_taken = |(br_nzp & CC_RESET).
- Reset asserted mid-write wins: no register or CC update occurs on that edge.

Write:
- On posedge clk with reg_we=1: R[dr] <= wdata.
- R0 is an ordinary writable register (LC-3 has no hardwired zero).
- reg_we=0: no register changes regardless of dr/wdata.

Read:
- Combinational (zero-cycle latency): ra = R[sr1], rb = R[sr2].
- Write-through bypass: if reg_we=1 and dr==sr1, ra = wdata in the same cycle; likewise rb when dr==sr2.
- sr1==sr2 is legal; both outputs show the same value.
- With the bypass, the ALU may consume a result written in the same cycle as the read; no stall logic is needed.

Condition codes:
- On posedge clk with ld_cc=1, nzp is loaded from wdata as a DATA_W-bit two's-complement value:
  - 3'b100 if wdata[DATA_W-1]=1.
  - 3'b010 if wdata==0.
  - 3'b001 otherwise.
- Exactly one bit is ever set, after reset or after any load.
- ld_cc is independent of reg_we. ld_cc=1 with reg_we=0 updates only the CC (used for test/debug); both high updates both on the same edge.
- nzp is registered: the new value is visible the cycle after the ld_cc edge.
- There is no bypass of nzp into br_taken.

Branch evaluation:
- br_taken = |(br_nzp & nzp), combinational from the registered nzp.
- br_nzp=3'b111 always gives 1; 3'b000 always gives 0.

Widths and limits:
- No arithmetic is performed; widths are exact.
- dr/sr values cover all 8 registers; there are no out-of-range values.

Test Plan:
- Reset: assert reset asynchronously mid-cycle after writing R3=16'h1234 -> R3 reads 0 immediately; nzp=3'b010; br_nzp=3'b010 gives br_taken=1, br_nzp=3'b101 gives br_taken=0.
- Write/read: write R5=16'hBEEF, then R2=16'h0007 on successive edges; set sr1=5, sr2=2 -> ra=16'hBEEF, rb=16'h0007; with reg_we=0 and dr=5, wdata=16'hFFFF, R5 is unchanged.
- Bypass: R1 holds 16'h0010; in one cycle set reg_we=1, dr=1, wdata=16'h0020, sr1=1, sr2=1 -> ra=rb=16'h0020 before the edge, and R1=16'h0020 after it.
- Condition codes: ld_cc with wdata=16'h8000 -> nzp=3'b100; with 16'h0000 -> 3'b010; with 16'h7FFF -> 3'b001; each takes effect one cycle after the edge. With br_nzp=3'b100, br_taken goes 1,0,0.
- Independence: ld_cc=1, reg_we=0, wdata=16'hFFFE -> nzp=3'b100 and no register changes. Then reg_we=1, ld_cc=0, dr=0, wdata=0 -> R0=0 and nzp stays 3'b100.
- ALU chain: write R4=16'h0003 and R6=16'hFFFE; drive ra/rb into the ALU (add, IR[5]=0); write the result 16'h0001 back to R7 with ld_cc=1 -> R7=16'h0001, nzp=3'b001, br_nzp=3'b001 gives br_taken=1.

Source files
------------

// File: rtl/lc3_regfile_cc.sv
// LC-3 register file (R0-R7) with write-through read bypass, NZP condition-code
// register and BR condition evaluation. Sits directly upstream of the ALU.
module lc3_regfile_cc #(
  parameter int unsigned DATA_W   = 16,
  parameter logic [2:0]  CC_RESET = 3'b010
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        sr1,
  input  logic [2:0]        sr2,
  input  logic [2:0]        dr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              reg_we,
  input  logic              ld_cc,
  input  logic [2:0]        br_nzp,
  output logic [DATA_W-1:0] ra,
  output logic [DATA_W-1:0] rb,
  output logic [2:0]        nzp,
  output logic              br_taken
);

  localparam int unsigned NumRegs = 8;

  logic [DATA_W-1:0] r_regs [NumRegs];
  logic [2:0]        r_nzp;

  logic [2:0]        w_cc_next;
  logic [DATA_W-1:0] w_ra;
  logic [DATA_W-1:0] w_rb;
  logic              w_byp_a;
  logic              w_byp_b;

  // Register storage: clear on reset, single write port otherwise. R0 is writable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NumRegs; i++) begin
        r_regs[i] <= '0;
      end
    end else if (reg_we) begin
      r_regs[dr] <= wdata;
    end
  end

  // Classify the writeback value as a two's-complement number; exactly one bit set.
  always_comb begin
    w_cc_next = 3'b001;
    if (wdata[DATA_W-1]) begin
      w_cc_next = 3'b100;
    end else if (wdata == '0) begin
      w_cc_next = 3'b010;
    end
  end

  // Condition-code register, loaded independently of the register write enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_nzp <= CC_RESET;
    end else if (ld_cc) begin
      r_nzp <= w_cc_next;
    end
  end

  // Combinational read ports with same-cycle bypass of the pending write.
  always_comb begin
    w_byp_a = reg_we && (dr == sr1);
    w_byp_b = reg_we && (dr == sr2);
    w_ra    = w_byp_a ? wdata : r_regs[sr1];
    w_rb    = w_byp_b ? wdata : r_regs[sr2];
    // Reset forces zero even if a write is being presented (bypass must not leak).
    if (reset) begin
      w_ra = '0;
      w_rb = '0;
    end
  end

  assign ra       = w_ra;
  assign rb       = w_rb;
  assign nzp      = r_nzp;
  // Uses the registered codes only; a same-cycle ld_cc does not affect the branch.
  assign br_taken = |(br_nzp & r_nzp);

endmodule

// File: tb/tb_lc3_regfile_cc.sv
// Self-checking bench for lc3_regfile_cc: directed test-plan steps followed by
// randomized cycles, all checked against an array-based reference model.
module tb_lc3_regfile_cc;

  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    sr1, sr2, dr, br_nzp;
  logic [DW-1:0] wdata;
  logic          reg_we, ld_cc;
  logic [DW-1:0] ra, rb;
  logic [2:0]    nzp;
  logic          br_taken;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] m_regs [8];
  logic [2:0]    m_nzp;

  always #5 clk = ~clk;

  lc3_regfile_cc #(
    .DATA_W  (DW),
    .CC_RESET(3'b010)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .sr1     (sr1),
    .sr2     (sr2),
    .dr      (dr),
    .wdata   (wdata),
    .reg_we  (reg_we),
    .ld_cc   (ld_cc),
    .br_nzp  (br_nzp),
    .ra      (ra),
    .rb      (rb),
    .nzp     (nzp),
    .br_taken(br_taken)
  );

  function automatic logic [2:0] cc_of(input logic [DW-1:0] v);
    if ($signed(v) < 0) return 3'b100;
    if (v == 0) return 3'b010;
    return 3'b001;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_nzp = 3'b010;
  endtask

  task automatic drive(input logic [2:0] s1, input logic [2:0] s2, input logic [2:0] d,
                       input logic [DW-1:0] wd, input logic we, input logic lc,
                       input logic [2:0] bn);
    sr1 = s1; sr2 = s2; dr = d; wdata = wd; reg_we = we; ld_cc = lc; br_nzp = bn;
  endtask

  // Compare every output against the model after inputs settle.
  task automatic check_all(input string tag);
    logic [DW-1:0] ea, eb;
    logic          eb_t;
    #1;
    if (reset) begin
      ea = '0;
      eb = '0;
    end else begin
      ea = (reg_we && dr == sr1) ? wdata : m_regs[sr1];
      eb = (reg_we && dr == sr2) ? wdata : m_regs[sr2];
    end
    eb_t = (br_nzp & m_nzp) != 3'b000;
    chk({tag, "_ra"}, ra, ea);
    chk({tag, "_rb"}, rb, eb);
    chk({tag, "_nzp"}, {13'd0, nzp}, {13'd0, m_nzp});
    chk({tag, "_br"}, {15'd0, br_taken}, {15'd0, eb_t});
  endtask

  // One clock edge: update the model with what the DUT saw, return at negedge.
  task automatic tick();
    @(posedge clk);
    if (!reset) begin
      if (reg_we) m_regs[dr] = wdata;
      if (ld_cc) m_nzp = cc_of(wdata);
    end
    @(negedge clk);
  endtask

  initial begin
    logic [DW-1:0] sum;
    reset = 1'b1;
    drive(3'd0, 3'd0, 3'd0, '0, 1'b0, 1'b0, 3'b000);
    model_reset();
    #2;
    check_all("rst_init");
    @(negedge clk);
    reset = 1'b0;

    // Reset mid-cycle after writing R3.
    drive(3'd3, 3'd3, 3'd3, 16'h1234, 1'b1, 1'b0, 3'b010);
    tick();
    drive(3'd3, 3'd3, 3'd0, '0, 1'b0, 1'b0, 3'b010);
    check_all("r3_written");
    chk("r3_val", ra, 16'h1234);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst_r3_zero", ra, 16'h0000);
    chk("rst_nzp", {13'd0, nzp}, 16'd2);
    chk("rst_br010", {15'd0, br_taken}, 16'd1);
    br_nzp = 3'b101;
    #1;
    chk("rst_br101", {15'd0, br_taken}, 16'd0);
    // Write and CC load presented while reset is held must be ignored.
    drive(3'd3, 3'd3, 3'd3, 16'h8765, 1'b1, 1'b1, 3'b101);
    check_all("rst_hold");
    tick();
    reset = 1'b0;
    drive(3'd3, 3'd3, 3'd0, '0, 1'b0, 1'b0, 3'b010);
    check_all("rst_won");

    // Write/read.
    drive(3'd0, 3'd0, 3'd5, 16'hBEEF, 1'b1, 1'b0, 3'b000);
    tick();
    drive(3'd0, 3'd0, 3'd2, 16'h0007, 1'b1, 1'b0, 3'b000);
    tick();
    drive(3'd5, 3'd2, 3'd5, 16'hFFFF, 1'b0, 1'b0, 3'b000);
    check_all("wr_rd");
    chk("wr_ra", ra, 16'hBEEF);
    chk("wr_rb", rb, 16'h0007);
    tick();
    chk("no_we_r5", ra, 16'hBEEF);

    // Bypass.
    drive(3'd0, 3'd0, 3'd1, 16'h0010, 1'b1, 1'b0, 3'b000);
    tick();
    drive(3'd1, 3'd1, 3'd1, 16'h0020, 1'b1, 1'b0, 3'b000);
    check_all("byp");
    chk("byp_ra", ra, 16'h0020);
    chk("byp_rb", rb, 16'h0020);
    tick();
    reg_we = 1'b0;
    check_all("byp_after");
    chk("byp_r1", ra, 16'h0020);

    // Condition codes, one cycle after the edge; BRn goes 1,0,0.
    drive(3'd0, 3'd0, 3'd0, 16'h8000, 1'b0, 1'b1, 3'b100);
    check_all("cc_pre");
    chk("cc_pre_old", {13'd0, nzp}, 16'd2);
    tick();
    drive(3'd0, 3'd0, 3'd0, 16'h0000, 1'b0, 1'b1, 3'b100);
    check_all("cc_neg");
    chk("cc_neg_br", {15'd0, br_taken}, 16'd1);
    tick();
    drive(3'd0, 3'd0, 3'd0, 16'h7FFF, 1'b0, 1'b1, 3'b100);
    check_all("cc_zero");
    chk("cc_zero_br", {15'd0, br_taken}, 16'd0);
    tick();
    ld_cc = 1'b0;
    check_all("cc_pos");
    chk("cc_pos_nzp", {13'd0, nzp}, 16'd1);

    // Independence of ld_cc and reg_we.
    drive(3'd0, 3'd5, 3'd5, 16'hFFFE, 1'b0, 1'b1, 3'b111);
    tick();
    check_all("ind_cc_only");
    chk("ind_nzp", {13'd0, nzp}, 16'd4);
    chk("ind_r5", rb, 16'hBEEF);
    drive(3'd0, 3'd0, 3'd0, 16'h0000, 1'b1, 1'b0, 3'b000);
    tick();
    reg_we = 1'b0;
    check_all("ind_r0");
    chk("ind_r0_nzp", {13'd0, nzp}, 16'd4);

    // ALU chain: R4 + R6 written back to R7 with CC load.
    drive(3'd0, 3'd0, 3'd4, 16'h0003, 1'b1, 1'b0, 3'b001);
    tick();
    drive(3'd0, 3'd0, 3'd6, 16'hFFFE, 1'b1, 1'b0, 3'b001);
    tick();
    drive(3'd4, 3'd6, 3'd0, '0, 1'b0, 1'b0, 3'b001);
    check_all("alu_rd");
    sum = ra + rb;
    drive(3'd7, 3'd7, 3'd7, sum, 1'b1, 1'b1, 3'b001);
    check_all("alu_wb");
    tick();
    reg_we = 1'b0;
    ld_cc = 1'b0;
    check_all("alu_done");
    chk("alu_r7", ra, 16'h0001);
    chk("alu_nzp", {13'd0, nzp}, 16'd1);
    chk("alu_br", {15'd0, br_taken}, 16'd1);

    // Randomized cycles with occasional asynchronous reset pulses.
    for (int n = 0; n < 300; n++) begin
      logic [DW-1:0] wd;
      case ($urandom_range(0, 3))
        0: wd = '0;
        1: wd = 16'h8000 | DW'($urandom);
        default: wd = DW'($urandom);
      endcase
      drive(3'($urandom), 3'($urandom), 3'($urandom), wd, 1'($urandom), 1'($urandom),
            3'($urandom));
      if ($urandom_range(0, 24) == 0) begin
        #2;
        reset = 1'b1;
        model_reset();
      end
      check_all("rnd");
      tick();
      reset = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
